// File: rtl/mvm_pkg.sv
// Shared types and helpers for the streaming matrix-vector multiplier.
// MVM_STREAM_SAT_EN selects saturating (defined) or wrapping (undefined) output conversion.
package mvm_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_A,
        LOAD_X,
        MAC,
        OUT,
        DONE
    } state_e;

    function automatic int acc_width(input int dw, input int n);
        return 2 * dw + $clog2(n);
    endfunction

    // Returns the sign-extended OW-bit result; an accumulator that already fits passes unchanged.
    function automatic logic signed [63:0] sat_trunc(input logic signed [63:0] acc, input int ow);
        logic signed [63:0] lim;
        logic signed [63:0] res;
        res = acc;
        lim = '0;
        if (ow < 64) begin
`ifdef MVM_STREAM_SAT_EN
            lim = (64'sd1 <<< (ow - 1)) - 64'sd1;
            if (acc > lim)
                res = lim;
            else if (acc < -lim - 64'sd1)
                res = -lim - 64'sd1;
`else
            lim = acc <<< (64 - ow);
            res = lim >>> (64 - ow);
`endif
        end
        return res;
    endfunction

endpackage

// File: rtl/mvm_mac.sv
// Signed multiply-accumulate: one product per enabled cycle, clear restarts the sum.
module mvm_mac #(
    parameter int DW   = 8,
    parameter int ACCW = 18
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   clear,
    input  logic                   en,
    input  logic signed [DW-1:0]   a,
    input  logic signed [DW-1:0]   b,
    output logic signed [ACCW-1:0] acc
);

    logic signed [2*DW-1:0] prod;
    logic signed [ACCW-1:0] acc_d;
    logic signed [ACCW-1:0] acc_q;

    always_comb begin
        prod  = a * b;
        acc_d = acc_q;
        if (en) begin
            if (clear)
                acc_d = ACCW'(prod);
            else
                acc_d = acc_q + ACCW'(prod);
        end
    end

    always_ff @(posedge clk) begin
        if (reset)
            acc_q <= '0;
        else
            acc_q <= acc_d;
    end

    assign acc = acc_q;

endmodule

// File: rtl/mvm_stream.sv
// Streaming y = A*x: loads A row-major then x, time-shares one MAC, emits one row per output beat.
// Output conversion saturates when MVM_STREAM_SAT_EN is defined, otherwise wraps.
module mvm_stream
    import mvm_pkg::*;
#(
    parameter int M  = 4,
    parameter int N  = 4,
    parameter int DW = 8,
    parameter int OW = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] data_in,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [OW-1:0] data_out,
    output logic          busy,
    output logic          done
);

    localparam int ACCW = acc_width(DW, N);
    localparam int RW   = (M > 1) ? $clog2(M) : 1;
    localparam int CW   = $clog2(N + 1);
    localparam int CIW  = (N > 1) ? $clog2(N) : 1;

    logic signed [DW-1:0] a_mem [M][N];
    logic signed [DW-1:0] x_mem [N];

    state_e          state_q, state_d;
    logic [RW-1:0]   row_q, row_d;
    logic [CW-1:0]   col_q, col_d;
    logic            in_ready_q, in_ready_d;
    logic            out_valid_q, out_valid_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic [OW-1:0]   data_out_q, data_out_d;

    logic                   in_fire;
    logic                   out_fire;
    logic                   mac_en;
    logic                   mac_clear;
    logic [CIW-1:0]         col_idx;
    logic signed [ACCW-1:0] acc;
    logic [OW-1:0]          conv;

    assign in_fire   = in_valid && in_ready_q;
    assign out_fire  = out_ready && out_valid_q;
    // col reaches N only on the drain cycle, where the MAC is idle
    assign col_idx   = (col_q == CW'(N)) ? '0 : col_q[CIW-1:0];
    assign mac_en    = (state_q == MAC) && (col_q != CW'(N));
    assign mac_clear = (col_q == '0);
    assign conv      = OW'(sat_trunc(64'(acc), OW));

    mvm_mac #(
        .DW  (DW),
        .ACCW(ACCW)
    ) u_mac (
        .clk  (clk),
        .reset(reset),
        .clear(mac_clear),
        .en   (mac_en),
        .a    (a_mem[row_q][col_idx]),
        .b    (x_mem[col_idx]),
        .acc  (acc)
    );

    always_comb begin
        state_d    = state_q;
        row_d      = row_q;
        col_d      = col_q;
        data_out_d = data_out_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = LOAD_A;
                    row_d   = '0;
                    col_d   = '0;
                end
            end
            LOAD_A: begin
                if (in_fire) begin
                    if (col_q == CW'(N - 1)) begin
                        col_d = '0;
                        if (row_q == RW'(M - 1)) begin
                            row_d   = '0;
                            state_d = LOAD_X;
                        end else begin
                            row_d = row_q + 1'b1;
                        end
                    end else begin
                        col_d = col_q + 1'b1;
                    end
                end
            end
            LOAD_X: begin
                if (in_fire) begin
                    if (col_q == CW'(N - 1)) begin
                        col_d   = '0;
                        row_d   = '0;
                        state_d = MAC;
                    end else begin
                        col_d = col_q + 1'b1;
                    end
                end
            end
            MAC: begin
                // N product cycles, then one cycle to register the finished sum
                if (col_q == CW'(N)) begin
                    col_d      = '0;
                    data_out_d = conv;
                    state_d    = OUT;
                end else begin
                    col_d = col_q + 1'b1;
                end
            end
            OUT: begin
                if (out_fire) begin
                    if (row_q == RW'(M - 1)) begin
                        state_d = DONE;
                    end else begin
                        row_d   = row_q + 1'b1;
                        state_d = MAC;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        in_ready_d  = (state_d == LOAD_A) || (state_d == LOAD_X);
        out_valid_d = (state_d == OUT);
        busy_d      = (state_d != IDLE);
        done_d      = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            row_q       <= '0;
            col_q       <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            data_out_q  <= '0;
        end else begin
            state_q     <= state_d;
            row_q       <= row_d;
            col_q       <= col_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            data_out_q  <= data_out_d;
        end
    end

    always_ff @(posedge clk) begin
        if (in_fire && state_q == LOAD_A)
            a_mem[row_q][col_idx] <= data_in;
        if (in_fire && state_q == LOAD_X)
            x_mem[col_idx] <= data_in;
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign data_out  = data_out_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule
